// File: rtl/axi_lite_wr_arbiter.sv
// Two-master to one-slave AXI4-Lite write-channel arbiter.
// One master owns AW, W and B for a complete write. Round-robin picks the owner when both request.
module axi_lite_wr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [1:0]              m_AWVALID,
   output logic [1:0]              m_AWREADY,
   input  logic [2*ADDR_W-1:0]     m_AWADDR,
   input  logic [5:0]              m_AWPROT,
   input  logic [1:0]              m_WVALID,
   output logic [1:0]              m_WREADY,
   input  logic [2*DATA_W-1:0]     m_WDATA,
   input  logic [2*DATA_W/8-1:0]   m_WSTRB,
   output logic [1:0]              m_BVALID,
   input  logic [1:0]              m_BREADY,
   output logic [3:0]              m_BRESP,
   output logic                    S_AWVALID,
   input  logic                    S_AWREADY,
   output logic [ADDR_W-1:0]       S_AWADDR,
   output logic [2:0]              S_AWPROT,
   output logic                    S_WVALID,
   input  logic                    S_WREADY,
   output logic [DATA_W-1:0]       S_WDATA,
   output logic [DATA_W/8-1:0]     S_WSTRB,
   input  logic                    S_BVALID,
   output logic                    S_BREADY,
   input  logic [1:0]              S_BRESP,
   output logic [1:0]              grant,
   output logic                    busy
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, XFER, RESP} state_e;

   state_e     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       rrLast_q, rrLast_d;
   logic       awDone_q, awDone_d;
   logic       wDone_q, wDone_d;

   logic gIdx;
   logic awHs;
   logic wHs;
   logic bHs;

   assign gIdx  = grant_q[1];
   assign awHs  = S_AWVALID & S_AWREADY;
   assign wHs   = S_WVALID & S_WREADY;
   assign bHs   = S_BVALID & S_BREADY;
   assign grant = grant_q;
   assign busy  = (state_q != IDLE);

   always_ff @(posedge ACLK) begin
      if (ARESETn) begin
         state_q  <= IDLE;
         grant_q  <= 2'b00;
         rrLast_q <= 1'b1;
         awDone_q <= 1'b0;
         wDone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rrLast_q <= rrLast_d;
         awDone_q <= awDone_d;
         wDone_q  <= wDone_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rrLast_d = rrLast_q;
      awDone_d = awDone_q;
      wDone_d  = wDone_q;
      case (state_q)
         IDLE: begin
            if (|m_AWVALID) begin
               state_d = XFER;
               // With both requesting, the master not served last wins.
               if (&m_AWVALID) grant_d = rrLast_q ? 2'b01 : 2'b10;
               else            grant_d = m_AWVALID;
            end
         end
         XFER: begin
            awDone_d = awDone_q | awHs;
            wDone_d  = wDone_q | wHs;
            if (awDone_d && wDone_d) begin
               state_d  = RESP;
               awDone_d = 1'b0;
               wDone_d  = 1'b0;
            end
         end
         RESP: begin
            if (bHs) begin
               rrLast_d = gIdx;
               grant_d  = 2'b00;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_AWREADY = 2'b00;
      m_WREADY  = 2'b00;
      m_BVALID  = 2'b00;
      m_BRESP   = 4'b0000;
      S_AWVALID = 1'b0;
      S_AWADDR  = '0;
      S_AWPROT  = 3'b000;
      S_WVALID  = 1'b0;
      S_WDATA   = '0;
      S_WSTRB   = '0;
      S_BREADY  = 1'b0;
      case (state_q)
         XFER: begin
            S_AWVALID       = m_AWVALID[gIdx] & ~awDone_q;
            S_WVALID        = m_WVALID[gIdx] & ~wDone_q;
            S_AWADDR        = gIdx ? m_AWADDR[ADDR_W +: ADDR_W] : m_AWADDR[0 +: ADDR_W];
            S_AWPROT        = gIdx ? m_AWPROT[5:3] : m_AWPROT[2:0];
            S_WDATA         = gIdx ? m_WDATA[DATA_W +: DATA_W] : m_WDATA[0 +: DATA_W];
            S_WSTRB         = gIdx ? m_WSTRB[STRB_W +: STRB_W] : m_WSTRB[0 +: STRB_W];
            // Ready is withheld once a channel is done so the owner never sees a second accept.
            m_AWREADY[gIdx] = S_AWREADY & ~awDone_q;
            m_WREADY[gIdx]  = S_WREADY & ~wDone_q;
         end
         RESP: begin
            m_BVALID[gIdx] = S_BVALID;
            S_BREADY       = m_BREADY[gIdx];
            if (gIdx) m_BRESP[3:2] = S_BRESP;
            else      m_BRESP[1:0] = S_BRESP;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_wr_arbiter.sv
// Self-checking bench for axi_lite_wr_arbiter: directed scenarios followed by
// randomized masters/slave compared against a transaction-level ownership model.
module tb_axi_lite_wr_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   logic [1:0]    mAwValid, mAwReady, mWValid, mWReady, mBValid, mBReady;
   logic [2*AW-1:0] mAwAddr;
   logic [5:0]    mAwProt;
   logic [2*DW-1:0] mWData;
   logic [2*SW-1:0] mWStrb;
   logic [3:0]    mBResp;
   logic          sAwValid, sAwReady, sWValid, sWReady, sBValid, sBReady;
   logic [AW-1:0] sAwAddr;
   logic [2:0]    sAwProt;
   logic [DW-1:0] sWData;
   logic [SW-1:0] sWStrb;
   logic [1:0]    sBResp;
   logic [1:0]    grant;
   logic          busy;

   always #5 clk = ~clk;

   axi_lite_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .ACLK(clk), .ARESETn(rst),
      .m_AWVALID(mAwValid), .m_AWREADY(mAwReady), .m_AWADDR(mAwAddr), .m_AWPROT(mAwProt),
      .m_WVALID(mWValid), .m_WREADY(mWReady), .m_WDATA(mWData), .m_WSTRB(mWStrb),
      .m_BVALID(mBValid), .m_BREADY(mBReady), .m_BRESP(mBResp),
      .S_AWVALID(sAwValid), .S_AWREADY(sAwReady), .S_AWADDR(sAwAddr), .S_AWPROT(sAwProt),
      .S_WVALID(sWValid), .S_WREADY(sWReady), .S_WDATA(sWData), .S_WSTRB(sWStrb),
      .S_BVALID(sBValid), .S_BREADY(sBReady), .S_BRESP(sBResp),
      .grant(grant), .busy(busy)
   );

   int checkCount = 0;
   int errorCount = 0;

   // Transaction-level model: who owns the slave and how far its write has progressed.
   int   owner;
   bit   lastServed;
   bit   awAcc, wAcc, respPh;
   bit   active[2], awPend[2], wPend[2];
   int   awDly[2], wDly[2];
   logic [31:0] txAddr[2], txData[2];
   logic [3:0]  txStrb[2];
   logic [2:0]  txProt[2];
   bit   sBv;
   logic [1:0] sBr;
   bit   eAwV, eWV;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic clearInputs();
      mAwValid = '0; mAwAddr = '0; mAwProt = '0; mWValid = '0; mWData = '0; mWStrb = '0;
      mBReady = '0; sAwReady = 1'b0; sWReady = 1'b0; sBValid = 1'b0; sBResp = 2'b00;
   endtask

   task automatic resetDut();
      clearInputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic resetModel();
      owner = -1; lastServed = 1'b1; awAcc = 0; wAcc = 0; respPh = 0; sBv = 0; sBr = 2'b00;
      for (int i = 0; i < 2; i++) begin
         active[i] = 0; awPend[i] = 0; wPend[i] = 0; awDly[i] = 0; wDly[i] = 0;
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < 2; i++) begin
         if (!active[i] && $urandom_range(0, 3) == 0) begin
            active[i] = 1; awPend[i] = 1; wPend[i] = 1;
            awDly[i] = int'($urandom_range(0, 3));
            wDly[i]  = int'($urandom_range(0, 4));
            txAddr[i] = $urandom; txData[i] = $urandom;
            txStrb[i] = 4'($urandom); txProt[i] = 3'($urandom);
         end
         mAwValid[i] = awPend[i] && (awDly[i] == 0);
         mWValid[i]  = wPend[i] && (wDly[i] == 0);
         if (awDly[i] > 0) awDly[i]--;
         if (wDly[i] > 0) wDly[i]--;
         mAwAddr[i*AW +: AW] = txAddr[i];
         mAwProt[i*3 +: 3]   = txProt[i];
         mWData[i*DW +: DW]  = txData[i];
         mWStrb[i*SW +: SW]  = txStrb[i];
         mBReady[i] = 1'($urandom_range(0, 1));
      end
      sAwReady = 1'($urandom_range(0, 1));
      sWReady  = 1'($urandom_range(0, 1));
      if (respPh && !sBv && $urandom_range(0, 1) == 1) begin
         sBv = 1; sBr = 2'($urandom);
      end
      sBValid = sBv;
      sBResp  = sBr;
   endtask

   task automatic checkCycle();
      logic [1:0] eGrant, eAwRdy, eWRdy, eBV;
      logic [3:0] eBResp;
      logic eBRdy;
      bit own;
      int oi;
      own = (owner >= 0);
      oi  = own ? owner : 0;
      eGrant = '0; eAwRdy = '0; eWRdy = '0; eBV = '0; eBResp = '0; eBRdy = 1'b0;
      if (own) eGrant[oi] = 1'b1;
      eAwV = own && !respPh && !awAcc && mAwValid[oi];
      eWV  = own && !respPh && !wAcc && mWValid[oi];
      if (own && !respPh && !awAcc) eAwRdy[oi] = sAwReady;
      if (own && !respPh && !wAcc)  eWRdy[oi]  = sWReady;
      if (respPh) begin
         eBV[oi] = sBValid;
         eBResp[2*oi +: 2] = sBResp;
         eBRdy = mBReady[oi];
      end
      checkOutput("grant", 64'(grant), 64'(eGrant));
      checkOutput("busy", 64'(busy), 64'(own));
      checkOutput("s_awvalid", 64'(sAwValid), 64'(eAwV));
      checkOutput("s_wvalid", 64'(sWValid), 64'(eWV));
      checkOutput("m_awready", 64'(mAwReady), 64'(eAwRdy));
      checkOutput("m_wready", 64'(mWReady), 64'(eWRdy));
      checkOutput("m_bvalid", 64'(mBValid), 64'(eBV));
      checkOutput("m_bresp", 64'(mBResp), 64'(eBResp));
      checkOutput("s_bready", 64'(sBReady), 64'(eBRdy));
      if (!own) begin
         checkOutput("idle_payload", 64'({sAwAddr, sAwProt, sWStrb}), 64'(0));
         checkOutput("idle_wdata", 64'(sWData), 64'(0));
      end else begin
         if (eAwV) checkOutput("s_awaddr", 64'({sAwAddr, sAwProt}), 64'({txAddr[oi], txProt[oi]}));
         if (eWV)  checkOutput("s_wdata", 64'({sWData, sWStrb}), 64'({txData[oi], txStrb[oi]}));
      end
   endtask

   // Advance the model across the clock edge using the handshakes the spec rules imply.
   task automatic updateModel();
      if (owner < 0) begin
         if (mAwValid != 2'b00) begin
            if (mAwValid == 2'b11) owner = lastServed ? 0 : 1;
            else                   owner = mAwValid[1] ? 1 : 0;
            awAcc = 0; wAcc = 0; respPh = 0;
         end
      end else if (!respPh) begin
         if (eAwV && sAwReady) begin awAcc = 1; awPend[owner] = 0; end
         if (eWV && sWReady)   begin wAcc = 1;  wPend[owner] = 0; end
         if (awAcc && wAcc) respPh = 1;
      end else if (sBValid && mBReady[owner]) begin
         active[owner] = 0;
         lastServed = (owner == 1);
         owner = -1; respPh = 0; awAcc = 0; wAcc = 0; sBv = 0;
      end
   endtask

   initial begin
      clearInputs();
      rst = 1'b1;
      resetModel();
      @(negedge clk);
      // Busy inputs while reset is held must not leak through.
      mAwValid = 2'b11; mWValid = 2'b11; mAwAddr = {32'h20, 32'h10}; mWData = '1;
      sAwReady = 1'b1; sWReady = 1'b1; sBValid = 1'b1; sBResp = 2'b11; mBReady = 2'b11;
      @(negedge clk); #1;
      checkOutput("rst_grant", 64'(grant), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_valids", 64'({sAwValid, sWValid, sBReady}), 64'(0));
      checkOutput("rst_readys", 64'({mAwReady, mWReady, mBValid}), 64'(0));
      checkOutput("rst_payload", 64'({sAwAddr, sAwProt, mBResp}), 64'(0));
      checkOutput("rst_wdata", 64'({sWData, sWStrb}), 64'(0));
      clearInputs();
      rst = 1'b0;

      // Single master write with OKAY response.
      @(negedge clk);
      mAwValid = 2'b01; mAwAddr[31:0] = 32'h0000_1000; mWValid = 2'b01;
      mWData[31:0] = 32'hDEAD_BEEF; mWStrb[3:0] = 4'hF; sAwReady = 1'b1; sWReady = 1'b1;
      #1;
      checkOutput("single_latency", 64'({grant, sAwValid}), 64'(0));
      @(negedge clk); #1;
      checkOutput("single_grant", 64'(grant), 64'(2'b01));
      checkOutput("single_awaddr", 64'({sAwValid, sAwAddr}), 64'({1'b1, 32'h1000}));
      checkOutput("single_w", 64'({sWValid, sWData, sWStrb}), 64'({1'b1, 32'hDEAD_BEEF, 4'hF}));
      checkOutput("single_readys", 64'({mAwReady, mWReady}), 64'(4'b0101));
      @(negedge clk);
      mAwValid = '0; mWValid = '0; sBValid = 1'b1; sBResp = 2'b00; mBReady = 2'b01;
      #1;
      checkOutput("single_b", 64'({mBValid, mBResp, sBReady}), 64'({2'b01, 4'b0000, 1'b1}));
      @(negedge clk);
      sBValid = 1'b0; mBReady = '0;
      #1;
      checkOutput("single_idle", 64'({grant, busy, mBValid}), 64'(0));

      // Error response held under backpressure for four cycles.
      @(negedge clk);
      mAwValid = 2'b01; mWValid = 2'b01; sAwReady = 1'b1; sWReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mAwValid = '0; mWValid = '0; sBValid = 1'b1; sBResp = 2'b10; mBReady = 2'b00;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("bp_hold", 64'({mBValid, mBResp, sBReady, busy}), 64'({2'b01, 4'b0010, 1'b0, 1'b1}));
         @(negedge clk);
      end
      mBReady = 2'b01;
      #1;
      checkOutput("bp_release", 64'({mBValid, sBReady}), 64'({2'b01, 1'b1}));
      @(negedge clk);
      sBValid = 1'b0; mBReady = '0;
      #1;
      checkOutput("bp_idle", 64'({grant, busy}), 64'(0));

      // Reset after AW accepted but before W.
      @(negedge clk);
      mAwValid = 2'b01; mAwAddr[31:0] = 32'h3000; sAwReady = 1'b1; sWReady = 1'b1;
      @(negedge clk); #1;
      checkOutput("mid_aw", 64'(sAwValid), 64'(1));
      @(negedge clk);
      mAwValid = '0;
      #1;
      checkOutput("mid_awdone", 64'({sAwValid, busy}), 64'(2'b01));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mWValid = 2'b01;
      #1;
      checkOutput("mid_reset", 64'({grant, busy, sAwValid, sWValid, mAwReady, mWReady}), 64'(0));
      mWValid = '0; mAwValid = 2'b10; mAwAddr[63:32] = 32'h20;
      @(negedge clk); #1;
      checkOutput("mid_regrant", 64'({grant, sAwAddr, mAwReady}), 64'({2'b10, 32'h20, 2'b10}));
      resetDut();

      // Both masters request continuously: owners alternate starting with master 0.
      mAwValid = 2'b11; mWValid = 2'b11; mAwAddr = {32'h20, 32'h10};
      sAwReady = 1'b1; sWReady = 1'b1; sBValid = 1'b1; sBResp = 2'b00; mBReady = 2'b11;
      for (int k = 0; k < 4; k++) begin
         repeat ((k == 0) ? 1 : 3) @(negedge clk);
         #1;
         checkOutput("rr_grant", 64'({grant, sAwAddr, mBValid}),
                     64'({((k % 2) == 0) ? 2'b01 : 2'b10, ((k % 2) == 0) ? 32'h10 : 32'h20, 2'b00}));
      end
      resetDut();

      // Randomized traffic against the ownership model.
      resetModel();
      repeat (2000) begin
         @(negedge clk);
         applyStimulus();
         #1;
         checkCycle();
         updateModel();
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/axi_lite_wr_arbiter.md
Name: axi_lite_wr_arbiter

Overview:
Two-master to one-slave AXI4-Lite write-channel arbiter. It sits between two write masters and a single write slave built from the team's write_address/write_data/write_response blocks. It grants the shared AW/W/B path to one master per complete write (AW + W + B) using round-robin priority. Read channels are out of scope.

Parameters:
ADDR_W, 32, address width of AWADDR
DATA_W, 32, data width of WDATA; STRB width = DATA_W/8

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  reset; synchronous, active-high (despite the name); 1 = reset
m_AWVALID  in  2  per-master AW valid, bit i = master i
m_AWREADY  out  2  per-master AW ready
m_AWADDR  in  2*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
m_AWPROT  in  6  master i at [i*3 +: 3]
m_WVALID  in  2  per-master W valid
m_WREADY  out  2  per-master W ready
m_WDATA  in  2*DATA_W  packed per master
m_WSTRB  in  2*DATA_W/8  packed per master
m_BVALID  out  2  per-master B valid
m_BREADY  in  2  per-master B ready
m_BRESP  out  4  master i at [i*2 +: 2]
S_AWVALID  out  1  to slave
S_AWREADY  in  1
S_AWADDR  out  ADDR_W
S_AWPROT  out  3
S_WVALID  out  1
S_WREADY  in  1
S_WDATA  out  DATA_W
S_WSTRB  out  DATA_W/8
S_BVALID  in  1
S_BREADY  out  1
S_BRESP  in  2
grant  out  2  one-hot owner; 00 when idle
busy  out  1  high in XFER or RESP

Behaviour:
- States: IDLE, XFER, RESP (registered). Registers: grant, rr_last (last served master), aw_done, w_done.
- Reset (ARESETn=1 at a clock edge): state=IDLE, grant=00, rr_last=1 (master 0 has first priority), aw_done=w_done=0. Reset wins over any concurrent handshake; a transaction in flight is abandoned with no completion. While in IDLE or reset, all S_*VALID, S_BREADY, m_*READY and m_BVALID are 0; S_AWADDR/S_AWPROT/S_WDATA/S_WSTRB are 0; m_BRESP is 0.
- IDLE: arbitration looks at m_AWVALID only. One requester: grant it. Both: grant the master != rr_last. Grant registers and the FSM moves to XFER on the same edge, so there is one cycle of latency from AWVALID to forwarding. W-before-AW from a master is allowed; that W stays un-readied until the grant.
- XFER: the granted master's AW and W are forwarded combinationally to the slave, and S_AWREADY/S_WREADY are returned to that master only.
  - S_AWVALID = m_AWVALID[g] & ~aw_done
  - S_WVALID = m_WVALID[g] & ~w_done
  - aw_done sets on S_AWVALID&S_AWREADY; w_done sets on S_WVALID&S_WREADY.
  - The two handshakes may complete in either order or in the same cycle.
  - When both are done (including same-cycle completion), the FSM goes to RESP next cycle and clears the flags.
- RESP: S_BVALID/S_BRESP route to m_BVALID[g]/m_BRESP[g], and m_BREADY[g] routes to S_BREADY. On the B handshake: rr_last <= g, grant <= 00, FSM goes to IDLE. A new grant needs a further cycle, so the minimum spacing between AW issues is one idle cycle.
- The non-granted master always sees READY=0 and BVALID=0. Its VALID/payload is ignored and must be held by the master per AXI rules.
- BRESP is passed through unmodified. The arbiter never retries.
- Outputs are not registered except grant/busy; no combinational path exists from S_*READY to S_*VALID.

Test Plan:
- Single master: m0 AW addr 0x0000_1000, W 0xDEADBEEF strb F, slave B OKAY -> grant=01 one cycle after AWVALID; S_AWADDR=0x1000; m_BVALID[0]=1 with BRESP 00; back to IDLE, grant=00.
- Simultaneous: m0 and m1 both request after reset -> m0 served first, then m1 (addrs 0x10, 0x20 appear in that order on S_AWADDR); repeated simultaneous requests alternate 1,0,1.
- Ordering: the slave accepts W 3 cycles before AW, then both in the same cycle on the next transaction -> each goes XFER->RESP exactly once; no duplicate S_WVALID after its handshake.
- Isolation: m1 asserts AWVALID/WVALID during m0's transaction -> m_AWREADY[1], m_WREADY[1], m_BVALID[1] stay 0 until m0's B handshake.
- Error passthrough and backpressure: slave returns BRESP=2'b10 with m_BREADY[0] low for 4 cycles -> m_BVALID[0] held 4 cycles with BRESP 10; completes on the 5th cycle.
- Reset mid-XFER after AW done, before W -> next cycle all outputs return to reset values and grant=00; the following request from m1 alone is granted normally.
